serial_group_adder: RTL and testbench



---
 rtl/serial_group_adder_pkg.sv | 9 +
 rtl/serial_group_adder_cla.sv | 42 ++++
 rtl/serial_group_adder.sv | 91 +++++++++
 tb/tb_serial_group_adder.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_group_adder_pkg.sv
// Shared helpers for the serial group adder: index-counter sizing.
package serial_group_adder_pkg;

  // A single group still needs a one-bit index register.
  function automatic int idx_width(input int group_count);
    return (group_count > 1) ? $clog2(group_count) : 1;
  endfunction

endpackage

// File: rtl/serial_group_adder_cla.sv
// Single-group carry-lookahead adder; every carry is a flat sum of generate/propagate products.
module carry_lookahead_adder #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH:0]   c;
  logic             prop;
  logic             acc;

  assign g = a & b;
  assign p = a ^ b;

  // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]carry_in, built from a running propagate product
  always_comb begin
    c    = '0;
    prop = 1'b0;
    acc  = 1'b0;
    c[0] = carry_in;
    for (int i = 0; i < WIDTH; i++) begin
      prop = p[i];
      acc  = g[i];
      for (int j = i - 1; j >= 0; j--) begin
        acc  = acc | (prop & g[j]);
        prop = prop & p[j];
      end
      acc    = acc | (prop & carry_in);
      c[i+1] = acc;
    end
  end

  assign sum       = p ^ c[WIDTH-1:0];
  assign carry_out = c[WIDTH];

endmodule

// File: rtl/serial_group_adder.sv
// Multi-cycle adder: one CLA group per clock, inter-group carry held in a register.
module serial_group_adder
  import serial_group_adder_pkg::*;
#(
  parameter int GROUP_WIDTH = 4,
  parameter int GROUP_COUNT = 2
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic                               carry_in,
  input  logic [GROUP_COUNT*GROUP_WIDTH-1:0] x,
  input  logic [GROUP_COUNT*GROUP_WIDTH-1:0] y,
  output logic                               ready,
  output logic [GROUP_COUNT*GROUP_WIDTH-1:0] z,
  output logic                               carry_out,
  output logic                               done
);

  localparam int TOTAL_WIDTH = GROUP_COUNT * GROUP_WIDTH;
  localparam int IDX_W       = idx_width(GROUP_COUNT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(GROUP_COUNT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                 state;
  logic [IDX_W-1:0]       idx;
  logic                   carry_q;
  logic [TOTAL_WIDTH-1:0] x_q;
  logic [TOTAL_WIDTH-1:0] y_q;
  logic [GROUP_WIDTH-1:0] cla_sum;
  logic                   cla_cout;
  int                     grp_lo;

  always_comb grp_lo = int'(idx) * GROUP_WIDTH;

  carry_lookahead_adder #(.WIDTH(GROUP_WIDTH)) u_cla (
    .a         (x_q[grp_lo +: GROUP_WIDTH]),
    .b         (y_q[grp_lo +: GROUP_WIDTH]),
    .carry_in  (carry_q),
    .sum       (cla_sum),
    .carry_out (cla_cout)
  );

  assign ready = (state != S_RUN);
  assign done  = (state == S_DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      idx       <= '0;
      carry_q   <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      z         <= '0;
      carry_out <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            x_q     <= x;
            y_q     <= y;
            carry_q <= carry_in;
            idx     <= '0;
            z       <= '0;
            state   <= S_RUN;
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          z[grp_lo +: GROUP_WIDTH] <= cla_sum;
          carry_q                  <= cla_cout;
          // The index parks on the last group instead of wrapping.
          if (idx == LAST_IDX) begin
            carry_out <= cla_cout;
            state     <= S_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_group_adder.sv
// Directed bench for serial_group_adder: default 4x2 instance plus 3x5 and 4x1 variants.
module tb_serial_group_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start, carry_in;
  logic [7:0] x, y, z;
  logic       ready, carry_out, done;

  logic        start5, cin5, ready5, cout5, done5;
  logic [14:0] x5, y5, z5;
  logic        start1, cin1, ready1, cout1, done1;
  logic [3:0]  x1, y1, z1;

  int checks = 0;
  int errors = 0;

  serial_group_adder dut (
    .clk(clk), .reset(reset), .start(start), .carry_in(carry_in),
    .x(x), .y(y), .ready(ready), .z(z), .carry_out(carry_out), .done(done)
  );

  serial_group_adder #(.GROUP_WIDTH(3), .GROUP_COUNT(5)) dut5 (
    .clk(clk), .reset(reset), .start(start5), .carry_in(cin5),
    .x(x5), .y(y5), .ready(ready5), .z(z5), .carry_out(cout5), .done(done5)
  );

  serial_group_adder #(.GROUP_WIDTH(4), .GROUP_COUNT(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .carry_in(cin1),
    .x(x1), .y(y1), .ready(ready1), .z(z1), .carry_out(cout1), .done(done1)
  );

  // Issue one operation on the default instance; lat counts edges after the accept edge until done.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic ci,
                       output logic [7:0] rz, output logic rc, output int lat, output int nrdy);
    @(negedge clk);
    x = a; y = b; carry_in = ci; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; lat = 0; nrdy = 0;
    while (!done && lat < 20) begin
      if (!ready) nrdy++;
      @(posedge clk); #1;
      lat++;
    end
    rz = z; rc = carry_out;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; carry_in = 1'b0; x = '0; y = '0;
    start5 = 1'b0; cin5 = 1'b0; x5 = '0; y5 = '0;
    start1 = 1'b0; cin1 = 1'b0; x1 = '0; y1 = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({ready, done, carry_out, z} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL reset_state: got rdy/done/cout/z %b%b%b/%h expected 100/00", ready, done, carry_out, z);
    end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_basic;
    logic [7:0] rz; logic rc; int lat, nrdy;
    do_op(8'h0F, 8'h01, 1'b0, rz, rc, lat, nrdy);
    checks++;
    if ({rc, rz} !== 9'h010 || lat != 2) begin
      errors++;
      $display("FAIL basic_0f_01: got %b/%h lat %0d expected 0/10 lat 2", rc, rz, lat);
    end
    checks++;
    if (nrdy != 2) begin
      errors++;
      $display("FAIL basic_ready_low: got %0d cycles expected 2", nrdy);
    end
    @(posedge clk); #1;
    checks++;
    if ({done, ready, carry_out, z} !== {1'b0, 1'b1, 1'b0, 8'h10}) begin
      errors++;
      $display("FAIL basic_hold_idle: got done/rdy/cout/z %b%b%b/%h expected 010/10", done, ready, carry_out, z);
    end
  endtask

  task automatic test_carry;
    logic [7:0] rz; logic rc; int lat, nrdy;
    do_op(8'hFF, 8'h01, 1'b0, rz, rc, lat, nrdy);
    checks++;
    if ({rc, rz} !== 9'h100 || lat != 2) begin
      errors++;
      $display("FAIL carry_ff_01: got %b/%h lat %0d expected 1/00 lat 2", rc, rz, lat);
    end
    do_op(8'hFF, 8'h00, 1'b1, rz, rc, lat, nrdy);
    checks++;
    if ({rc, rz} !== 9'h100 || lat != 2) begin
      errors++;
      $display("FAIL carry_ff_00_cin: got %b/%h lat %0d expected 1/00 lat 2", rc, rz, lat);
    end
    do_op(8'h5A, 8'h3C, 1'b1, rz, rc, lat, nrdy);
    checks++;
    if ({rc, rz} !== 9'h097) begin
      errors++;
      $display("FAIL carry_5a_3c_cin: got %b/%h expected 0/97", rc, rz);
    end
  endtask

  task automatic test_back_to_back;
    int done_cyc[$];
    logic [8:0] res[$];
    @(negedge clk);
    x = 8'h12; y = 8'h34; carry_in = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    x = 8'h80; y = 8'h80;
    for (int c = 1; c <= 7; c++) begin
      @(posedge clk); #1;
      if (c == 3) start = 1'b0;
      if (done) begin done_cyc.push_back(c); res.push_back({carry_out, z}); end
    end
    checks++;
    if (done_cyc.size() != 2 || done_cyc[0] != 2 || done_cyc[1] != 5) begin
      errors++;
      $display("FAIL b2b_done_spacing: got %0d pulses first %0d expected pulses at 2 and 5",
               done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1);
    end else begin
      checks++;
      if (res[0] !== 9'h046) begin
        errors++;
        $display("FAIL b2b_first: got %h expected 046", res[0]);
      end
      checks++;
      if (res[1] !== 9'h100) begin
        errors++;
        $display("FAIL b2b_second: got %h expected 100", res[1]);
      end
    end
  endtask

  task automatic test_start_ignored;
    int ndone = 0;
    @(negedge clk);
    x = 8'h01; y = 8'h01; carry_in = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    x = 8'hAA; y = 8'hAA; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (done) begin
        ndone++;
        checks++;
        if ({carry_out, z} !== 9'h002) begin
          errors++;
          $display("FAIL ignore_result: got %h expected 002", {carry_out, z});
        end
      end
      @(posedge clk);
    end
    checks++;
    if (ndone != 1) begin
      errors++;
      $display("FAIL ignore_done_count: got %0d expected 1", ndone);
    end
  endtask

  task automatic test_reset_mid_run;
    logic [7:0] rz; logic rc; int lat, nrdy;
    int ndone = 0;
    @(negedge clk);
    x = 8'hF0; y = 8'h0F; carry_in = 1'b0; start = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (z !== 8'h0F || ready !== 1'b0) begin
      errors++;
      $display("FAIL midrun_partial: got z %h rdy %b expected 0f 0", z, ready);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if ({ready, done, carry_out, z} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL midrun_async_reset: got %b%b%b/%h expected 100/00", ready, done, carry_out, z);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    checks++;
    if (ndone != 0) begin
      errors++;
      $display("FAIL midrun_no_done: got %0d pulses expected 0", ndone);
    end
    do_op(8'h03, 8'h04, 1'b0, rz, rc, lat, nrdy);
    checks++;
    if ({rc, rz} !== 9'h007 || lat != 2) begin
      errors++;
      $display("FAIL after_reset_op: got %b/%h lat %0d expected 0/07 lat 2", rc, rz, lat);
    end
  endtask

  task automatic test_sweep;
    logic [7:0] a, b, rz; logic ci, rc; int lat, nrdy;
    logic [8:0] want;
    for (int n = 0; n < 300; n++) begin
      a = 8'($urandom); b = 8'($urandom); ci = 1'($urandom);
      want = {1'b0, a} + {1'b0, b} + {8'h00, ci};
      do_op(a, b, ci, rz, rc, lat, nrdy);
      checks++;
      if ({rc, rz} !== want || lat != 2) begin
        errors++;
        $display("FAIL sweep %h+%h+%b: got %h lat %0d expected %h lat 2", a, b, ci, {rc, rz}, lat, want);
      end
    end
  endtask

  task automatic test_params;
    logic [14:0] a5 [3] = '{15'h7FFF, 15'h1234, 15'h5555};
    logic [14:0] b5 [3] = '{15'h0001, 15'h0ABC, 15'h2AAA};
    logic        c5 [3] = '{1'b0, 1'b0, 1'b1};
    logic [15:0] w5 [3] = '{16'h8000, 16'h1CF0, 16'h8000};
    logic [3:0]  a1 [3] = '{4'hF, 4'h3, 4'h9};
    logic [3:0]  b1 [3] = '{4'h1, 4'h4, 4'h6};
    logic        c1 [3] = '{1'b0, 1'b1, 1'b1};
    logic [4:0]  w1 [3] = '{5'h10, 5'h08, 5'h10};
    int lat;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      x5 = a5[k]; y5 = b5[k]; cin5 = c5[k]; start5 = 1'b1;
      @(posedge clk); #1;
      start5 = 1'b0; lat = 0;
      while (!done5 && lat < 20) begin @(posedge clk); #1; lat++; end
      checks++;
      if ({cout5, z5} !== w5[k] || lat != 5) begin
        errors++;
        $display("FAIL g3x5_op%0d: got %h lat %0d expected %h lat 5", k, {cout5, z5}, lat, w5[k]);
      end
      @(negedge clk);
      x1 = a1[k]; y1 = b1[k]; cin1 = c1[k]; start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0; lat = 0;
      while (!done1 && lat < 20) begin @(posedge clk); #1; lat++; end
      checks++;
      if ({cout1, z1} !== w1[k] || lat != 1) begin
        errors++;
        $display("FAIL g4x1_op%0d: got %h lat %0d expected %h lat 1", k, {cout1, z1}, lat, w1[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_back_to_back();
    test_start_ignored();
    test_reset_mid_run();
    test_params();
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
